// File: rtl/sample_feeder.sv
// sample_feeder: training-sample store that answers a level request with
// one registered sample and a one-cycle dataReady pulse, flagging epoch end.
module sample_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    rewind,
  input  logic                    wrEn,
  input  logic signed [WIDTH-1:0] wrX1,
  input  logic signed [WIDTH-1:0] wrX2,
  input  logic signed [WIDTH-1:0] wrT,
  input  logic                    requestFlag,
  output logic                    dataReady,
  output logic signed [WIDTH-1:0] x1,
  output logic signed [WIDTH-1:0] x2,
  output logic signed [WIDTH-1:0] t,
  output logic                    flagEOF,
  output logic [AW:0]             count,
  output logic                    empty,
  output logic                    full
);

  localparam logic [AW:0] DepthC = DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    RELEASE
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [WIDTH-1:0]     x1_q, x1_d;
  logic [WIDTH-1:0]     x2_q, x2_d;
  logic [WIDTH-1:0]     t_q, t_d;
  logic                 eof_q, eof_d;
  logic [3*WIDTH-1:0]   mem_q [DEPTH];
  logic [3*WIDTH-1:0]   rd_word;
  logic                 full_w;
  logic                 wr_acc;
  logic                 fetch_en;
  logic                 fetch_eof;
  logic                 present;

  assign full_w    = (count_q == DepthC);
  assign wr_acc    = wrEn && !full_w && !clear;
  assign rd_word   = mem_q[rd_ptr_q];
  // EOF is judged against the count seen in the FETCH cycle
  assign fetch_eof = ({1'b0, rd_ptr_q} == (count_q - 1'b1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (requestFlag && (count_q != '0)) begin
            state_d = FETCH;
          end
        end
        FETCH: state_d = PRESENT;
        PRESENT: begin
          state_d = requestFlag ? RELEASE : IDLE;
        end
        RELEASE: begin
          if (!requestFlag) begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    present  = 1'b0;
    fetch_en = 1'b0;
    unique case (state_q)
      IDLE:    ;
      FETCH:   fetch_en = !clear;
      PRESENT: present  = 1'b1;
      RELEASE: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    t_d      = t_q;
    eof_d    = eof_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      if (fetch_en) begin
        x1_d     = rd_word[3*WIDTH-1:2*WIDTH];
        x2_d     = rd_word[2*WIDTH-1:WIDTH];
        t_d      = rd_word[WIDTH-1:0];
        eof_d    = fetch_eof;
        rd_ptr_d = fetch_eof ? '0 : rd_ptr_q + 1'b1;
      end
      // rewind outranks the fetch advance so it governs the next fetch
      if (rewind) begin
        rd_ptr_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      t_q      <= '0;
      eof_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      t_q      <= t_d;
      eof_q    <= eof_d;
    end
  end

  // Sample store has no reset; contents are meaningless until written
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= {wrX1, wrX2, wrT};
    end
  end

  assign dataReady = present;
  assign x1        = x1_q;
  assign x2        = x2_q;
  assign t         = t_q;
  assign flagEOF   = eof_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = full_w;

endmodule

// File: tb/tb_sample_feeder.sv
// Scoreboard bench for sample_feeder: a queue-based sample model predicts
// each delivery; a monitor compares every dataReady pulse.
module tb_sample_feeder;
  localparam int W = 8;
  localparam int D = 16;
  localparam int A = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic rewind = 1'b0;
  logic wrEn = 1'b0;
  logic signed [W-1:0] wrX1 = '0;
  logic signed [W-1:0] wrX2 = '0;
  logic signed [W-1:0] wrT = '0;
  logic requestFlag = 1'b0;
  logic dataReady;
  logic signed [W-1:0] x1, x2, t;
  logic flagEOF;
  logic [A:0] count;
  logic empty, full;

  always #5 clk = ~clk;

  sample_feeder #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
    .clk(clk), .rst(rst), .clear(clear), .rewind(rewind),
    .wrEn(wrEn), .wrX1(wrX1), .wrX2(wrX2), .wrT(wrT),
    .requestFlag(requestFlag), .dataReady(dataReady),
    .x1(x1), .x2(x2), .t(t), .flagEOF(flagEOF),
    .count(count), .empty(empty), .full(full)
  );

  typedef struct {
    int x1;
    int x2;
    int t;
    bit eof;
  } exp_t;

  exp_t sbq[$];
  int m1[$], m2[$], m3[$];
  int rd;
  int checks;
  int errors;
  int pulses;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic void model_clear();
    m1.delete(); m2.delete(); m3.delete();
    rd = 0;
  endfunction

  function automatic void expect_next();
    exp_t e;
    if (m1.size() == 0) return;
    e.x1  = m1[rd];
    e.x2  = m2[rd];
    e.t   = m3[rd];
    e.eof = (rd == m1.size() - 1);
    rd    = e.eof ? 0 : rd + 1;
    sbq.push_back(e);
  endfunction

  task automatic mwrite(input int a, input int b, input int c);
    wrEn = 1'b1;
    wrX1 = W'(a);
    wrX2 = W'(b);
    wrT  = W'(c);
    tick();
    wrEn = 1'b0;
    if (m1.size() < D) begin
      m1.push_back(a); m2.push_back(b); m3.push_back(c);
    end
  endtask

  task automatic do_clear(input bit with_wr);
    clear = 1'b1;
    wrEn  = with_wr;
    wrX1  = 8'sd9;
    tick();
    clear = 1'b0;
    wrEn  = 1'b0;
    model_clear();
    chk("clear_count", int'(count), 0);
    chk("clear_empty", int'(empty), 1);
  endtask

  task automatic req(input bit rw);
    int lat;
    bit got;
    if (rw) rd = 0;
    expect_next();
    rewind = rw;
    requestFlag = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 8 && !got; i++) begin
      tick();
      rewind = 1'b0;
      if (dataReady) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk("req_latency", lat, 2);
    if (!got && sbq.size() > 0) void'(sbq.pop_back());
    requestFlag = 1'b0;
    tick();
  endtask

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    int p0;
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && dataReady) begin
          pulses++;
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse x1=%0d x2=%0d t=%0d",
                     x1, x2, t);
          end else begin
            e = sbq.pop_front();
            if (int'(x1) !== e.x1 || int'(x2) !== e.x2 ||
                int'(t) !== e.t || flagEOF !== e.eof) begin
              errors++;
              $display("FAIL sample got %0d,%0d,%0d eof=%0b want %0d,%0d,%0d eof=%0b",
                       x1, x2, t, flagEOF, e.x1, e.x2, e.t, e.eof);
            end
          end
        end
      end
    join_none

    model_clear();
    tick();
    tick();
    chk("rst_ready", int'(dataReady), 0);
    chk("rst_x1", int'(x1), 0);
    chk("rst_t", int'(t), 0);
    chk("rst_eof", int'(flagEOF), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    rst = 1'b0;
    tick();

    // Request against an empty store stays pending
    p0 = pulses;
    requestFlag = 1'b1;
    repeat (10) tick();
    chk("empty_no_pulse", pulses - p0, 0);
    mwrite(3, -2, 1);
    expect_next();
    chk("pend_c1", int'(dataReady), 0);
    tick();
    chk("pend_c2", int'(dataReady), 0);
    tick();
    chk("pend_pulse", int'(dataReady), 1);
    requestFlag = 1'b0;
    tick();
    do_clear(1'b0);

    // Fixed epoch with wrap
    mwrite(1, 1, 1);
    mwrite(2, 2, -1);
    mwrite(3, 3, 1);
    mwrite(4, 4, -1);
    chk("count4", int'(count), 4);
    repeat (6) req(1'b0);

    // Level request held: one pulse only
    expect_next();
    p0 = pulses;
    requestFlag = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("hold_pulse", int'(dataReady), int'(i == 2));
    end
    requestFlag = 1'b0;
    tick();
    chk("hold_once", pulses - p0, 1);

    // Rewind together with request
    do_clear(1'b0);
    mwrite(1, 1, 1);
    mwrite(2, 2, -1);
    mwrite(3, 3, 1);
    mwrite(4, 4, -1);
    req(1'b0);
    req(1'b0);
    req(1'b1);

    // Fill past DEPTH
    do_clear(1'b0);
    for (int i = 0; i < D + 1; i++) mwrite(rnd8(), rnd8(), rnd8());
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), D);
    for (int i = 0; i < D + 1; i++) req(1'b0);
    do_clear(1'b1);
    chk("clr_wr_full", int'(full), 0);

    // Randomized mix of requests, rewinds and epoch-extending writes
    for (int i = 0; i < int'($urandom_range(1, D)); i++)
      mwrite(rnd8(), rnd8(), rnd8());
    for (int it = 0; it < 40; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0 && m1.size() < D) mwrite(rnd8(), rnd8(), rnd8());
      else req(r == 1);
      repeat ($urandom_range(0, 2)) tick();
    end
    chk("rand_count", int'(count), m1.size());

    // Reset during FETCH
    do_clear(1'b0);
    mwrite(5, 6, 7);
    mwrite(8, 9, 10);
    req(1'b0);
    requestFlag = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("rstf_ready", int'(dataReady), 0);
    chk("rstf_x1", int'(x1), 0);
    chk("rstf_x2", int'(x2), 0);
    chk("rstf_eof", int'(flagEOF), 0);
    chk("rstf_count", int'(count), 0);
    p0 = pulses;
    tick();
    rst = 1'b0;
    requestFlag = 1'b0;
    model_clear();
    repeat (4) tick();
    chk("rstf_no_pulse", pulses - p0, 0);
    mwrite(11, 12, 13);
    mwrite(14, 15, 16);
    req(1'b0);

    repeat (3) tick();
    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
